// File: rtl/json_rx_pkg.sv
// Shared types and ASCII constants for the JSON feedback-frame receiver.
package json_rx_pkg;

  typedef enum logic [2:0] {
    StHunt,
    StBody,
    StValue,
    StWaitNl,
    StHold
  } json_rx_state_t;

  localparam logic [7:0] LBRACE  = 8'h7B;
  localparam logic [7:0] RBRACE  = 8'h7D;
  localparam logic [7:0] QUOTE   = 8'h22;
  localparam logic [7:0] COLON   = 8'h3A;
  localparam logic [7:0] MINUS   = 8'h2D;
  localparam logic [7:0] CR      = 8'h0D;
  localparam logic [7:0] LF      = 8'h0A;
  localparam logic [7:0] DIGIT_0 = 8'h30;

  // Byte expected at each position of the '"' key '"' ':' pattern.
  function automatic logic [7:0] match_char(input logic [1:0] idx, input logic [7:0] key);
    logic [7:0] c;
    unique case (idx)
      2'd0:    c = QUOTE;
      2'd1:    c = key;
      2'd2:    c = QUOTE;
      default: c = COLON;
    endcase
    return c;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] x);
    return (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

endpackage

// File: rtl/json_int_acc.sv
// Decimal accumulator: acc = acc*10 + digit, saturating at 32767, with an optional sign.
module json_int_acc (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               digit_en,
  input  logic [3:0]         digit,
  input  logic               neg_en,
  output logic signed [15:0] result
);

  logic [14:0] acc_q;
  logic        neg_q;
  logic [19:0] acc_next;

  assign acc_next = 20'(acc_q) * 20'd10 + 20'(digit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      neg_q <= 1'b0;
    end else if (clear) begin
      acc_q <= '0;
      neg_q <= 1'b0;
    end else begin
      if (neg_en) begin
        neg_q <= 1'b1;
      end
      if (digit_en) begin
        acc_q <= (acc_next > 20'd32767) ? 15'h7FFF : acc_next[14:0];
      end
    end
  end

  assign result = neg_q ? -$signed({1'b0, acc_q}) : $signed({1'b0, acc_q});

endmodule

// File: rtl/json_frame_rx.sv
// Frames '{...}\n' JSON lines from the rover byte stream and extracts the integer value of KEY_CHAR.
// Optional good/bad frame counters are built when JSON_RX_STATS_EN is defined.
module json_frame_rx
  import json_rx_pkg::*;
#(
  parameter int unsigned MAX_LEN        = 64,
  parameter logic [7:0]  KEY_CHAR       = 8'h54,
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic [15:0] key_value,
  output logic [7:0]  frame_len,
  output logic        err_overflow,
  output logic        err_format,
  output logic        err_timeout,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_bad
);

  localparam int unsigned IdleW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  json_rx_state_t     state_q;
  logic [7:0]         len_q;
  logic [1:0]         match_q;
  logic               key_found_q;
  logic               first_q;
  logic [IdleW-1:0]   idle_q;

  logic               accept, in_frame, expire, overflow, is_digit;
  logic               value_step, value_end, body_step;
  logic               acc_clear, acc_neg, acc_digit;
  logic signed [15:0] acc_result;

  always_comb begin
    accept     = rx_valid && rx_ready;
    in_frame   = state_q inside {StBody, StValue, StWaitNl};
    expire     = in_frame && (idle_q == IdleW'(TIMEOUT_CYCLES - 1));
    overflow   = accept && in_frame && !expire && ((32'(len_q) + 32'd1) > MAX_LEN);
    is_digit   = (rx_byte >= DIGIT_0) && (rx_byte <= DIGIT_0 + 8'd9);
    value_step = accept && !expire && !overflow && (state_q == StValue);
    acc_neg    = value_step && first_q && (rx_byte == MINUS);
    acc_digit  = value_step && is_digit;
    // The first non-digit in VALUE closes the number and is re-examined as a BODY byte.
    value_end  = value_step && !is_digit && !acc_neg;
    body_step  = accept && !expire && !overflow && ((state_q == StBody) || value_end);
    acc_clear  = body_step && (match_q == 2'd3) && (rx_byte == COLON);
  end

  json_int_acc u_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (acc_clear),
    .digit_en (acc_digit),
    .digit    (rx_byte[3:0]),
    .neg_en   (acc_neg),
    .result   (acc_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StHunt;
      len_q        <= '0;
      match_q      <= '0;
      key_found_q  <= 1'b0;
      first_q      <= 1'b0;
      idle_q       <= '0;
      rx_ready     <= 1'b1;
      frame_valid  <= 1'b0;
      key_value    <= '0;
      frame_len    <= '0;
      err_overflow <= 1'b0;
      err_format   <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      err_overflow <= 1'b0;
      err_format   <= 1'b0;
      err_timeout  <= 1'b0;

      if (!in_frame || accept || expire) begin
        idle_q <= '0;
      end else begin
        idle_q <= idle_q + 1'b1;
      end

      if (expire) begin
        // A byte landing on the expiry cycle is treated as if the receiver were hunting.
        err_timeout <= 1'b1;
        state_q     <= StHunt;
        if (accept && (rx_byte == LBRACE)) begin
          state_q     <= StBody;
          len_q       <= 8'd1;
          key_found_q <= 1'b0;
          match_q     <= '0;
        end
      end else if (overflow) begin
        err_overflow <= 1'b1;
        state_q      <= StHunt;
      end else if (state_q == StHold) begin
        if (frame_ready) begin
          frame_valid <= 1'b0;
          rx_ready    <= 1'b1;
          state_q     <= StHunt;
        end
      end else if (accept) begin
        unique case (state_q)
          StHunt: begin
            if (rx_byte == LBRACE) begin
              state_q     <= StBody;
              len_q       <= 8'd1;
              key_found_q <= 1'b0;
              match_q     <= '0;
            end
          end
          StBody, StValue: begin
            len_q <= len_q + 8'd1;
            if ((state_q == StValue) && !value_end) begin
              first_q <= 1'b0;
            end else begin
              if (value_end) begin
                key_value   <= acc_result;
                key_found_q <= 1'b1;
                state_q     <= StBody;
              end
              if (rx_byte == LBRACE) begin
                err_format  <= 1'b1;
                state_q     <= StBody;
                len_q       <= 8'd1;
                key_found_q <= 1'b0;
                match_q     <= '0;
              end else if (rx_byte == RBRACE) begin
                state_q <= StWaitNl;
                match_q <= '0;
              end else if (acc_clear) begin
                state_q <= StValue;
                match_q <= '0;
                first_q <= 1'b1;
              end else if (rx_byte == match_char(match_q, KEY_CHAR)) begin
                match_q <= match_q + 2'd1;
              end else begin
                match_q <= (rx_byte == QUOTE) ? 2'd1 : 2'd0;
              end
            end
          end
          default: begin
            len_q <= len_q + 8'd1;
            if ((rx_byte == LF) && key_found_q) begin
              state_q     <= StHold;
              frame_valid <= 1'b1;
              rx_ready    <= 1'b0;
              frame_len   <= len_q + 8'd1;
            end else if (rx_byte == LBRACE) begin
              err_format  <= 1'b1;
              state_q     <= StBody;
              len_q       <= 8'd1;
              key_found_q <= 1'b0;
              match_q     <= '0;
            end else if (rx_byte != CR) begin
              err_format <= 1'b1;
              state_q    <= StHunt;
            end
          end
        endcase
      end
    end
  end

`ifdef JSON_RX_STATS_EN
  logic fv_prev_q;

  // Counters trail the event pulses by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fv_prev_q  <= 1'b0;
      frames_ok  <= '0;
      frames_bad <= '0;
    end else begin
      fv_prev_q <= frame_valid;
      if (frame_valid && !fv_prev_q) begin
        frames_ok <= sat_inc(frames_ok);
      end
      if (err_overflow || err_format || err_timeout) begin
        frames_bad <= sat_inc(frames_bad);
      end
    end
  end
`else
  assign frames_ok  = '0;
  assign frames_bad = '0;
`endif

endmodule

// File: tb/tb_json_frame_rx.sv
// Randomized scoreboard bench for json_frame_rx: frames are generated from a menu of shapes and
// their expected results are derived from the framing rules, then checked by an independent monitor.
module tb_json_frame_rx;

  localparam int unsigned MaxLen  = 64;
  localparam int unsigned Timeout = 200;

  typedef struct {
    logic [15:0] val;
    logic [7:0]  len;
  } exp_frame_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_ready;
  logic        frame_valid;
  logic        frame_ready;
  logic [15:0] key_value;
  logic [7:0]  frame_len;
  logic        err_overflow, err_format, err_timeout;
  logic [15:0] frames_ok, frames_bad;

  exp_frame_t  exp_frames[$];
  logic [2:0]  exp_errs[$];   // {overflow, format, timeout}
  int          checks = 0;
  int          errors = 0;
  int          n_good = 0;
  int          n_err  = 0;
  int          gap_max = 2;
  bit          hold_off = 1'b0;

  localparam logic [2:0] EOvf = 3'b100;
  localparam logic [2:0] EFmt = 3'b010;
  localparam logic [2:0] ETmo = 3'b001;

  json_frame_rx #(
    .MAX_LEN        (MaxLen),
    .KEY_CHAR       (8'h54),
    .TIMEOUT_CYCLES (Timeout)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_byte      (rx_byte),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .frame_valid  (frame_valid),
    .frame_ready  (frame_ready),
    .key_value    (key_value),
    .frame_len    (frame_len),
    .err_overflow (err_overflow),
    .err_format   (err_format),
    .err_timeout  (err_timeout),
    .frames_ok    (frames_ok),
    .frames_bad   (frames_bad)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  task automatic push_frame(input string s, input int val);
    exp_frame_t e;
    e.val = 16'(val);
    e.len = 8'(s.len());
    exp_frames.push_back(e);
    n_good++;
  endtask

  task automatic push_err(input logic [2:0] code);
    exp_errs.push_back(code);
    n_err++;
  endtask

  // Returns at posedge+1 just after the byte was taken.
  task automatic send_byte(input logic [7:0] b);
    int  n;
    logic rdy;
    if (gap_max > 0) begin
      repeat ($urandom_range(0, gap_max)) begin
        @(posedge clk);
        #1;
      end
    end
    rx_byte  = b;
    rx_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      rdy = rx_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 3000);
    if (!rdy) fail("rx_ready_wait_expired");
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_frames.size() != 0 || frame_valid) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) fail("drain_wait_expired");
    repeat (3) @(posedge clk);
    #1;
  endtask

  function automatic int clamp_val(input int mag, input bit neg);
    int m;
    m = (mag > 32767) ? 32767 : mag;
    return neg ? -m : m;
  endfunction

  task automatic rand_value(output string vs, output int val);
    int mag;
    bit neg;
    case ($urandom_range(0, 2))
      0:       mag = $urandom_range(0, 9);
      1:       mag = $urandom_range(0, 32767);
      default: mag = $urandom_range(32760, 99999);
    endcase
    neg = 1'($urandom_range(0, 1));
    vs  = neg ? {"-", $sformatf("%0d", mag)} : $sformatf("%0d", mag);
    val = clamp_val(mag, neg);
  endtask

  task automatic rand_good(output string s, output int val);
    string pre, post, vs;
    case ($urandom_range(0, 3))
      0:       pre = "";
      1:       pre = "\"L\":0.5,";
      2:       pre = "\"nT\":12,";
      default: pre = "\"a\":\"T\",";
    endcase
    case ($urandom_range(0, 3))
      0:       post = "";
      1:       post = ",\"L\":0.5";
      2:       post = ",\"x\":-3";
      default: post = " ";
    endcase
    rand_value(vs, val);
    s = {"{", pre, "\"T\":", vs, post, "}", ($urandom_range(0, 1) != 0) ? "\015" : "", "\n"};
  endtask

  // Frame of total length len: '{' + spaces + '"T":7}\n'.
  task automatic len_frame(input int len);
    string s;
    s = "{";
    for (int i = 0; i < len - 8; i++) s = {s, " "};
    s = {s, "\"T\":7}\n"};
    if (len <= int'(MaxLen)) push_frame(s, 7);
    else push_err(EOvf);
    send_str(s);
  endtask

  // Monitor: pops the scoreboard whenever the DUT pulses an error or hands over a frame.
  initial begin : monitor
    exp_frame_t ef;
    logic [2:0] got;
    logic [2:0] ee;
    frame_ready = 1'b0;
    forever begin
      @(negedge clk);
      got = {err_overflow, err_format, err_timeout};
      if (got != 3'b000) begin
        if (exp_errs.size() == 0) begin
          fail($sformatf("unexpected_err got=%b", got));
        end else begin
          ee = exp_errs.pop_front();
          check("err_kind", 32'(got), 32'(ee));
        end
      end
      frame_ready = hold_off ? 1'b0 : ($urandom_range(0, 2) != 0);
      if (frame_valid) begin
        check("rx_ready_low_in_hold", 32'(rx_ready), 32'd0);
        if (frame_ready) begin
          if (exp_frames.size() == 0) begin
            fail("unexpected_frame");
          end else begin
            ef = exp_frames.pop_front();
            check("key_value", 32'(key_value), 32'(ef.val));
            check("frame_len", 32'(frame_len), 32'(ef.len));
          end
        end
      end
    end
  end

  initial begin : stimulus
    string s, vs, s2;
    int    val, val2, n;

    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    #23;
    check("rst_rx_ready", 32'(rx_ready), 32'd1);
    check("rst_frame_valid", 32'(frame_valid), 32'd0);
    check("rst_key_value", 32'(key_value), 32'd0);
    check("rst_frame_len", 32'(frame_len), 32'd0);
    check("rst_errs", 32'({err_overflow, err_format, err_timeout}), 32'd0);
    check("rst_counters", {frames_ok, frames_bad}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: basic frame, valid the cycle after the '\n' handshake
    s = "{\"T\":1001,\"L\":0.5}\n";
    push_frame(s, 1001);
    send_str(s);
    check("t1_latency_valid", 32'(frame_valid), 32'd1);
    wait_drain();

    // 2: consumer stalls 10 clocks
    hold_off = 1'b1;
    s = "{\"T\":-42}\n";
    push_frame(s, -42);
    send_str(s);
    check("t2_latency_valid", 32'(frame_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t2_hold_valid", 32'(frame_valid), 32'd1);
      check("t2_hold_value", 32'(key_value), 32'h0000_FFD6);
      check("t2_hold_len", 32'(frame_len), 32'd10);
    end
    hold_off = 1'b0;
    wait_drain();
    check("t2_rx_ready_back", 32'(rx_ready), 32'd1);

    // 3: key missing
    push_err(EFmt);
    send_str("{\"L\":0.5}\n");

    // 4: overflow, then recovery
    push_err(EOvf);
    send_byte(8'h7B);
    for (int i = 0; i < 70; i++) send_byte("a");
    s = "{\"T\":7}\n";
    push_frame(s, 7);
    send_str(s);
    len_frame(64);
    len_frame(65);
    wait_drain();

    // 5: timeout exactly once, then receiver is hunting
    push_err(ETmo);
    send_str("{\"T\":5");
    repeat (Timeout + 50) @(posedge clk);
    #1;
    send_str("\"T\":1}\n");
    s = "{\"T\":12}\n";
    push_frame(s, 12);
    send_str(s);

    // 6: saturation and mid-frame resync
    s = "{\"T\":99999}\n";
    push_frame(s, 32767);
    send_str(s);
    push_err(EFmt);
    s = "{\"T\":4}\n";
    push_frame(s, 4);
    send_str({"{\"T\":3", s});
    wait_drain();

    // Randomized mix
    for (int it = 0; it < 80; it++) begin
      n = $urandom_range(0, 3);
      for (int g = 0; g < n; g++) begin
        s = "ab \n}:\"T";
        send_byte(s[$urandom_range(0, s.len() - 1)]);
      end
      case ($urandom_range(0, 6))
        0, 1: begin
          rand_good(s, val);
          push_frame(s, val);
          send_str(s);
        end
        2: begin
          push_err(EFmt);
          if ($urandom_range(0, 1) != 0) send_str("{\"L\":12}\n");
          else send_str("{\"T\":5}x\n");
        end
        3: len_frame($urandom_range(58, 70));
        4: begin
          rand_value(vs, val);
          rand_good(s2, val2);
          push_err(EFmt);
          push_frame(s2, val2);
          send_str({"{\"T\":", vs, s2});
        end
        default: begin
          rand_value(vs, val);
          rand_value(s2, val2);
          s = {"{\"T\":", vs, ",\"T\":", s2, "}\n"};
          push_frame(s, val2);
          send_str(s);
        end
      endcase
    end
    wait_drain();
    repeat (5) @(posedge clk);
    #1;

    check("final_frames_left", 32'(exp_frames.size()), 32'd0);
    check("final_errs_left", 32'(exp_errs.size()), 32'd0);
`ifdef JSON_RX_STATS_EN
    check("frames_ok", 32'(frames_ok), 32'(n_good));
    check("frames_bad", 32'(frames_bad), 32'(n_err));
`else
    check("frames_ok_tied", 32'(frames_ok), 32'd0);
    check("frames_bad_tied", 32'(frames_bad), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
